// File: rtl/uart_prog_loader.sv
// Program-memory loader for the Brainfuck CPU: receives 8N1 UART bytes, stores
// the eight command characters from address 0 and zero-pads up to PROG_LEN.
module uart_prog_loader #(
  parameter int unsigned PROG_ADDR_WIDTH = 14,
  parameter int unsigned PROG_LEN        = 16383,
  parameter int unsigned CLKS_PER_BIT    = 104,
  parameter logic [7:0]  TERMINATOR      = 8'h04
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       uart_rx,
  input  logic                       load_req,
  output logic                       prog_we,
  output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
  output logic [7:0]                 prog_wr,
  output logic                       loaded,
  output logic                       busy,
  output logic                       overflow,
  output logic                       frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PROG_ADDR_WIDTH-1:0] ADDR_LAST = PROG_ADDR_WIDTH'(PROG_LEN - 1);
  localparam logic [PROG_ADDR_WIDTH-1:0] ADDR_END  = PROG_ADDR_WIDTH'(PROG_LEN);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} u_state_t;
  typedef enum logic [1:0] {L_IDLE, L_RECV, L_FILL, L_DONE} l_state_t;

  logic                       r_rx_meta, r_rx_sync;
  u_state_t                   r_u_state, w_u_state_nxt;
  logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
  logic [2:0]                 r_bit_idx, w_bit_idx_nxt;
  logic [7:0]                 r_shift, w_shift_nxt;
  logic                       r_rx_valid, w_rx_valid_nxt;
  logic                       w_stop_bad;

  l_state_t                   r_l_state, w_l_state_nxt;
  logic [PROG_ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic                       w_we_nxt, w_loaded_nxt, w_busy_nxt, w_ovf_nxt, w_fe_nxt;
  logic [PROG_ADDR_WIDTH-1:0] w_paddr_nxt;
  logic [7:0]                 w_pwr_nxt;
  logic                       w_is_cmd;

  // UART receiver next-state
  always_comb begin
    w_u_state_nxt  = r_u_state;
    w_cnt_nxt      = r_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_shift_nxt    = r_shift;
    w_rx_valid_nxt = 1'b0;
    w_stop_bad     = 1'b0;
    case (r_u_state)
      U_IDLE: begin
        w_cnt_nxt = '0;
        if (!r_rx_sync) w_u_state_nxt = U_START;
      end
      U_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
          w_u_state_nxt = r_rx_sync ? U_IDLE : U_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      U_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rx_sync, r_shift[7:1]};
          if (r_bit_idx == 3'd7) w_u_state_nxt = U_STOP;
          else                   w_bit_idx_nxt = r_bit_idx + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      U_STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt      = '0;
          w_u_state_nxt  = U_IDLE;
          w_rx_valid_nxt = r_rx_sync;
          w_stop_bad     = !r_rx_sync;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_u_state_nxt = U_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_u_state  <= U_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_meta  <= uart_rx;
      r_rx_sync  <= r_rx_meta;
      r_u_state  <= w_u_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_rx_valid <= w_rx_valid_nxt;
    end
  end

  always_comb begin
    case (r_shift)
      8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C: w_is_cmd = 1'b1;
      default:                                                 w_is_cmd = 1'b0;
    endcase
  end

  // Loader next-state; load_req restarts from any state
  always_comb begin
    w_l_state_nxt = r_l_state;
    w_addr_nxt    = r_addr;
    w_we_nxt      = 1'b0;
    w_paddr_nxt   = prog_addr;
    w_pwr_nxt     = prog_wr;
    w_loaded_nxt  = loaded;
    w_ovf_nxt     = overflow;
    w_fe_nxt      = frame_err | w_stop_bad;
    if (load_req) begin
      w_l_state_nxt = L_RECV;
      w_addr_nxt    = '0;
      w_loaded_nxt  = 1'b0;
      w_ovf_nxt     = 1'b0;
      w_fe_nxt      = w_stop_bad;
    end else begin
      case (r_l_state)
        L_IDLE: ;
        L_RECV: begin
          if (r_rx_valid) begin
            if (w_is_cmd) begin
              w_we_nxt    = 1'b1;
              w_paddr_nxt = r_addr;
              w_pwr_nxt   = r_shift;
              w_addr_nxt  = r_addr + 1'b1;
              if (r_addr == ADDR_LAST) begin
                w_ovf_nxt     = 1'b1;
                w_l_state_nxt = L_DONE;
              end
            end else if (r_shift == TERMINATOR) begin
              w_l_state_nxt = L_FILL;
            end
          end
        end
        L_FILL: begin
          if (r_addr == ADDR_END) begin
            w_l_state_nxt = L_DONE;
          end else begin
            w_we_nxt    = 1'b1;
            w_paddr_nxt = r_addr;
            w_pwr_nxt   = 8'h00;
            w_addr_nxt  = r_addr + 1'b1;
            if (r_addr == ADDR_LAST) w_l_state_nxt = L_DONE;
          end
        end
        L_DONE: begin
          w_loaded_nxt  = 1'b1;
          w_l_state_nxt = L_IDLE;
        end
        default: w_l_state_nxt = L_IDLE;
      endcase
    end
    // busy drops together with the rise of loaded
    w_busy_nxt = (w_l_state_nxt != L_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_l_state <= L_IDLE;
      r_addr    <= '0;
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_wr   <= '0;
      loaded    <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      r_l_state <= w_l_state_nxt;
      r_addr    <= w_addr_nxt;
      prog_we   <= w_we_nxt;
      prog_addr <= w_paddr_nxt;
      prog_wr   <= w_pwr_nxt;
      loaded    <= w_loaded_nxt;
      busy      <= w_busy_nxt;
      overflow  <= w_ovf_nxt;
      frame_err <= w_fe_nxt;
    end
  end

endmodule
